ps2_receptor: RTL and testbench
===============================

Name: ps2_receptor

Overview:
Serial front end of the keyboard path. Synchronises and deglitches the raw PS/2 clock/data lines, deserialises 11-bit device-to-host frames, and presents each scan-code byte with a one-cycle completion tick. Sits directly upstream of the make/break acquisition FSM, which consumes dout_o and rx_done_tick_o.

Parameters:
FILTER_LEN, 8, number of consecutive equal samples of synchronised ps2c needed to change the filtered clock level.
TIMEOUT_CYCLES, 10000, system-clock cycles without a PS/2 falling edge that abort a partial frame; 100 us at 100 MHz.

Ports:
Clock_i  in  1  system clock; all logic on rising edge.
Reset_i  in  1  asynchronous, active-low reset.
ps2d_i  in  1  raw PS/2 data line, asynchronous.
ps2c_i  in  1  raw PS/2 clock line, asynchronous.
rx_en_i  in  1  receive enable; sampled only in IDLE.
dout_o  out  8  last received scan code, held between frames.
rx_done_tick_o  out  1  one-cycle pulse; a new byte is on dout_o.
frame_err_o  out  1  one-cycle pulse on a rejected frame; see Optional Feature.

Behaviour:
- Reset, Reset_i low, asynchronous: FSM to IDLE; dout_o=0x00; rx_done_tick_o=0; frame_err_o=0; synchronisers and filter shift register all 1s; filtered clock=1; bit counter and timeout counter 0. A partial frame is discarded.
- Input conditioning: ps2c_i and ps2d_i each pass through a 2-FF synchroniser.
  - The synchronised clock shifts into a FILTER_LEN-bit register.
  - Filtered clock goes to 1 when the register is all 1s, to 0 when it is all 0s, and otherwise holds.
  - fall_edge is a one-cycle strobe when the filtered clock goes 1 to 0.
  - A glitch shorter than FILTER_LEN cycles produces no edge.
- Frame format, LSB first: start(0), d0..d7, odd parity, stop(1).
  - An 11-bit shift register shifts right on each accepted fall_edge, with synchronised ps2d loaded into the MSB.
  - After 11 bits: b[0]=start, b[8:1]=data, b[9]=parity, b[10]=stop.
- FSM states IDLE, DPS, LOAD:
  - IDLE: on fall_edge with rx_en_i=1, shift in the start bit, load the bit counter with 9, go to DPS. A fall_edge with rx_en_i=0 is ignored.
  - DPS: on each fall_edge, shift in. If the counter is 0, go to LOAD and register dout_o<=b[8:1] (the post-shift value) on the same edge. Otherwise decrement the counter.
  - LOAD: lasts one cycle; rx_done_tick_o=1; go to IDLE unconditionally.
- dout_o is valid in the cycle rx_done_tick_o is high. It stays stable until the next accepted frame, so the consumer may read it one or more cycles after the tick.
- Timeout:
  - The counter clears on every fall_edge and in IDLE, and counts while in DPS.
  - Reaching TIMEOUT_CYCLES-1 in DPS sends the FSM to IDLE. The partial frame is dropped, there is no tick, and dout_o is unchanged.
  - If a fall_edge and the timeout coincide, the edge wins.
- rx_en_i deasserted mid-frame does not abort; the frame completes.
- Latency: from the 11th raw ps2c falling edge, the tick comes after 2 (sync) + FILTER_LEN (filter) + 1 (FSM) cycles, within +/-1 cycle.
- Only one tick per frame; back-to-back frames need no idle gap beyond the PS/2 stop bit.

Optional Feature:
Macro: PS2_FRAME_CHECK_EN.
- Defined: in LOAD, the frame is accepted only if b[0]=0, b[10]=1 and ^b[9:1]=1 (odd parity).
  - Accepted: rx_done_tick_o pulses, dout_o updates.
  - Rejected: frame_err_o pulses for one cycle, no rx_done_tick_o, dout_o keeps its previous value. dout_o is therefore loaded in LOAD rather than on the DPS edge, and the tick moves one cycle later.
  - A timeout abort also pulses frame_err_o.
- Undefined: no checking; every completed frame ticks; frame_err_o is tied to 0.

Test Plan:
- Reset with Reset_i=0 mid-operation, then release -> dout_o=0x00, no tick; a following frame with data 0x1D -> one rx_done_tick_o, dout_o=0x1D.
- Frame 0xF0, then frame 0x1C, with ps2c period 60 us at 100 MHz -> two ticks; dout_o=0xF0, then 0x1C; dout_o stable for at least 100 cycles after each tick.
- 3-cycle low glitch on ps2c_i while IDLE -> no state change, no tick; next frame 0x5A -> dout_o=0x5A.
- Send 5 bits, hold ps2c high for TIMEOUT_CYCLES+10 -> back to IDLE, no tick, dout_o unchanged; then full frame 0x23 -> dout_o=0x23.
- rx_en_i=0 at the start bit -> frame ignored. rx_en_i dropped after the start bit -> frame 0x1B still received.
- PS2_FRAME_CHECK_EN defined, frame 0x1D with even parity -> frame_err_o one pulse, no tick, dout_o holds its prior value. Same frame with stop=0 -> same response.

Source files
------------

// File: rtl/ps2_receptor.sv
// ps2_receptor: PS/2 device-to-host receiver (sync, clock deglitch, 11-bit deserialiser).
// Optional frame checking with PS2_FRAME_CHECK_EN; revision 1.0.
`default_nettype none

module ps2_receptor #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       Clock_i,
    input  logic       Reset_i,
    input  logic       ps2d_i,
    input  logic       ps2c_i,
    input  logic       rx_en_i,
    output logic [7:0] dout_o,
    output logic       rx_done_tick_o,
    output logic       frame_err_o
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] c_TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DPS  = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;

    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_filter;
    logic                  r_fclk;
    logic                  w_fall;

    logic [1:0]            r_state;
    logic [10:0]           r_bits;
    logic [3:0]            r_cnt;
    logic [TMO_W-1:0]      r_tmo;
    logic [7:0]            r_dout;
    logic [10:0]           w_shift;

    always_ff @(posedge Clock_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_c_sync <= '1;
            r_d_sync <= '1;
            r_filter <= '1;
            r_fclk   <= 1'b1;
        end else begin
            r_c_sync <= {r_c_sync[0], ps2c_i};
            r_d_sync <= {r_d_sync[0], ps2d_i};
            r_filter <= {r_c_sync[1], r_filter[FILTER_LEN-1:1]};
            if (&r_filter) begin
                r_fclk <= 1'b1;
            end else if (~|r_filter) begin
                r_fclk <= 1'b0;
            end
        end
    end

    // Strobe fires in the single cycle where the filter is all zeros but the level is still high.
    assign w_fall  = r_fclk & ~|r_filter;
    assign w_shift = {r_d_sync[1], r_bits[10:1]};

`ifdef PS2_FRAME_CHECK_EN
    logic r_done;
    logic r_err;
    logic w_frame_ok;

    assign w_frame_ok = ~r_bits[0] & r_bits[10] & (^r_bits[9:1]);
`else
    logic w_unused;

    assign w_unused = r_bits[0];
`endif

    always_ff @(posedge Clock_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_state <= c_IDLE;
            r_bits  <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_dout  <= '0;
`ifdef PS2_FRAME_CHECK_EN
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
`ifdef PS2_FRAME_CHECK_EN
            r_done <= 1'b0;
            r_err  <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    r_tmo <= '0;
                    if (w_fall && rx_en_i) begin
                        r_bits  <= w_shift;
                        r_cnt   <= 4'd9;
                        r_state <= c_DPS;
                    end
                end
                c_DPS: begin
                    // A falling edge takes priority over an expiring timeout.
                    if (w_fall) begin
                        r_bits <= w_shift;
                        r_tmo  <= '0;
                        if (r_cnt == 4'd0) begin
                            r_state <= c_LOAD;
`ifndef PS2_FRAME_CHECK_EN
                            r_dout  <= w_shift[8:1];
`endif
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end else if (r_tmo == c_TMO_MAX) begin
                        r_tmo   <= '0;
                        r_state <= c_IDLE;
`ifdef PS2_FRAME_CHECK_EN
                        r_err   <= 1'b1;
`endif
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_LOAD: begin
                    r_tmo   <= '0;
                    r_state <= c_IDLE;
`ifdef PS2_FRAME_CHECK_EN
                    if (w_frame_ok) begin
                        r_dout <= r_bits[8:1];
                        r_done <= 1'b1;
                    end else begin
                        r_err  <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign dout_o = r_dout;

`ifdef PS2_FRAME_CHECK_EN
    assign rx_done_tick_o = r_done;
    assign frame_err_o    = r_err;
`else
    assign rx_done_tick_o = (r_state == c_LOAD);
    assign frame_err_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_receptor.sv
// tb_ps2_receptor: randomized PS/2 frames checked against a queue-based behavioural model.
`default_nettype none

module tb_ps2_receptor;

    localparam int FL  = 8;
    localparam int TO  = 10000;
`ifdef PS2_FRAME_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2d  = 1'b1;
    logic       ps2c  = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] dout;
    logic       tick;
    logic       ferr;

    ps2_receptor #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Clock_i        (clk),
        .Reset_i        (rst_n),
        .ps2d_i         (ps2d),
        .ps2c_i         (ps2c),
        .rx_en_i        (rx_en),
        .dout_o         (dout),
        .rx_done_tick_o (tick),
        .frame_err_o    (ferr)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_last = 8'h00;
    int         err_pending = 0;
    int         lat_start = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~^d;
        if (bad_par) p = ~p;
        return {~bad_stop, p, d, 1'b0};
    endfunction

    function automatic bit frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
    endfunction

    // Drive nbits of frame f; on the 11th falling edge register the model's expectation.
    task automatic send(input logic [10:0] f, input int nbits, input bit drop_en,
                        input bit accept, input bit expect_err);
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            repeat ($urandom_range(20, 40)) @(posedge clk);
            #1 ps2c = 1'b0;
            if (i == 10) begin
                lat_start = accept ? cyc : -1;
                if (accept) exp_q.push_back(f[8:1]);
                else if (expect_err) err_pending++;
            end
            repeat ($urandom_range(20, 40)) @(posedge clk);
            #1 ps2c = 1'b1;
            if (drop_en && i == 0) rx_en = 1'b0;
        end
        ps2d = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (40) @(posedge clk);
        check(name, exp_q.size() + err_pending, 0);
    endtask

    task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit drop_en);
        logic [10:0] f;
        bit          ok;
        f  = make_frame(d, bad_par, bad_stop);
        ok = (CHK == 0) || frame_ok(f);
        send(f, 11, drop_en, ok, !ok);
        drain("frame_drain");
        rx_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!(dout == model_last || (exp_q.size() > 0 && dout == exp_q[0]))) begin
                errors++;
                $display("FAIL dout_hold: got 0x%0h, expected 0x%0h (t=%0t)", dout, model_last, $time);
            end
            if (tick) begin
                check("tick_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("tick_dout", dout, exp_q[0]);
                    model_last = exp_q.pop_front();
                    if (lat_start >= 0) begin
                        checks++;
                        if (cyc - lat_start < 10 || cyc - lat_start > 12 + CHK) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, expected 10..%0d", cyc - lat_start, 12 + CHK);
                        end
                        lat_start = -1;
                    end
                end
            end
            if (ferr) begin
                check("err_pending", err_pending > 0, 1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    initial begin
        #1_000_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        check("model_frame_1D", make_frame(8'h1D, 1'b0, 1'b0), 11'h63A);
        check("model_frame_F0", make_frame(8'hF0, 1'b0, 1'b0), 11'h7E0);
        check("model_badpar", frame_ok(make_frame(8'h1D, 1'b1, 1'b0)), 0);
        check("model_badstop", frame_ok(make_frame(8'h1D, 1'b0, 1'b1)), 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_tick", tick, 0);
        check("reset_err", ferr, 0);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        d = 8'($urandom()) | 8'h01;
        frame(d, 0, 0, 0);
        check("pre_reset_dout", dout, d);
        send(make_frame(8'h77, 0, 0), 4, 0, 0, 0);
        #3 rst_n = 1'b0;
        @(negedge clk);
        check("midreset_dout", dout, 8'h00);
        check("midreset_tick", tick, 0);
        exp_q.delete();
        err_pending = 0;
        model_last  = 8'h00;
        lat_start   = -1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("post_reset_dout", dout, 8'h00);
        frame(8'h1D, 0, 0, 0);
        check("frame_1D", dout, 8'h1D);

        frame(8'hF0, 0, 0, 0);
        check("frame_F0", dout, 8'hF0);
        frame(8'h1C, 0, 0, 0);
        repeat (100) @(posedge clk);
        check("frame_1C_hold", dout, 8'h1C);

        @(posedge clk); #1 ps2c = 1'b0;
        repeat (3) @(posedge clk); #1 ps2c = 1'b1;
        repeat (30) @(posedge clk);
        check("glitch_no_change", dout, 8'h1C);
        frame(8'h5A, 0, 0, 0);
        check("frame_5A", dout, 8'h5A);

        send(make_frame(8'h99, 0, 0), 5, 0, 0, 0);
        err_pending += CHK;
        repeat (TO + 10) @(posedge clk);
        drain("timeout_drain");
        check("timeout_dout", dout, 8'h5A);
        frame(8'h23, 0, 0, 0);
        check("frame_23", dout, 8'h23);

        rx_en = 1'b0;
        send(make_frame(8'h44, 0, 0), 11, 0, 0, 0);
        drain("rxen_off_drain");
        check("rxen_off_dout", dout, 8'h23);
        rx_en = 1'b1;
        frame(8'h1B, 0, 0, 1);
        check("frame_1B_drop_en", dout, 8'h1B);

        frame(8'h1D, 1, 0, 0);
        check("badpar_dout", dout, CHK ? 8'h1B : 8'h1D);
        frame(8'h1D, 0, 1, 0);
        check("badstop_dout", dout, CHK ? 8'h1B : 8'h1D);

        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom());
            frame(d, 0, 0, 0);
            check("rand_frame", dout, d);
        end

        check("final_queue", exp_q.size() + err_pending, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
